// File: rtl/top_writeback.sv
// Writeback stage: commits ALU/load results to the 32-entry integer register file,
// advances the PC, and maintains the retired/jump/cycle counters.
module top_writeback #(
  parameter int              XLEN           = 64,
  parameter int              OPLEN          = 8,
  parameter int              RF_WE_BIT      = 0,
  parameter int              WB_SRC_MEM_BIT = 1,
  parameter logic [XLEN-1:0] RESET_VECTOR   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             phase_writeback,
  input  logic [OPLEN-1:0] decoded_op_mw,
  input  logic             jump_state_mw,
  input  logic [4:0]       rdsel_mw,
  input  logic [XLEN-1:0]  next_pc_mw,
  input  logic [XLEN-1:0]  alu_out_mw,
  input  logic [XLEN-1:0]  mem_out_mw,
  input  logic [4:0]       rs1sel,
  input  logic [4:0]       rs2sel,
  output logic [XLEN-1:0]  rs1data,
  output logic [XLEN-1:0]  rs2data,
  output logic [XLEN-1:0]  current_pc,
  output logic [63:0]      instret_count,
  output logic [63:0]      cycle_count,
  output logic [31:0]      jump_count,
  output logic             pc_misalign
);

  logic [XLEN-1:0]            wb_data;
  logic                       rf_wr;
  logic                       pc_ok;
  logic [31:1][XLEN-1:0]      regs;
  logic [31:0][XLEN-1:0]      rf_view;

  assign wb_data = decoded_op_mw[WB_SRC_MEM_BIT] ? mem_out_mw : alu_out_mw;
  assign rf_wr   = phase_writeback && decoded_op_mw[RF_WE_BIT] && (rdsel_mw != 5'd0);
  assign pc_ok   = (next_pc_mw[1:0] == 2'b00);

  // x0 has no storage; the read view hardwires it to zero.
  assign rf_view[0] = '0;
  for (genvar i = 1; i < 32; i++) begin : g_rf
    assign rf_view[i] = regs[i];

    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n)
        regs[i] <= '0;
      else if (rf_wr && (rdsel_mw == 5'(i)))
        regs[i] <= wb_data;
    end
  end

  // Bypass lets decode see the value being committed this very cycle.
  always_comb begin
    rs1data = rf_view[rs1sel];
    rs2data = rf_view[rs2sel];
    if (rf_wr && (rs1sel == rdsel_mw)) rs1data = wb_data;
    if (rf_wr && (rs2sel == rdsel_mw)) rs2data = wb_data;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      current_pc    <= RESET_VECTOR;
      instret_count <= '0;
      jump_count    <= '0;
      cycle_count   <= '0;
      pc_misalign   <= 1'b0;
    end else begin
      cycle_count <= cycle_count + 64'd1;
      pc_misalign <= phase_writeback && !pc_ok;
      if (phase_writeback) begin
        // A misaligned target is dropped but the instruction still retires.
        if (pc_ok) current_pc <= next_pc_mw;
        instret_count <= instret_count + 64'd1;
        if (jump_state_mw) jump_count <= jump_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_top_writeback.sv
// Randomized bench for top_writeback: a behavioural model of the architectural state
// is compared against the DUT every cycle, plus directed literal checks.
module tb_top_writeback;
  localparam int XLEN = 64;
  localparam int OPLEN = 8;
  localparam int WE = 0;
  localparam int MEM = 1;

  logic clk = 0;
  logic rst_n = 1;
  logic phase_writeback = 0;
  logic [OPLEN-1:0] decoded_op_mw = '0;
  logic jump_state_mw = 0;
  logic [4:0] rdsel_mw = '0, rs1sel = '0, rs2sel = '0;
  logic [XLEN-1:0] next_pc_mw = '0, alu_out_mw = '0, mem_out_mw = '0;
  logic [XLEN-1:0] rs1data, rs2data, current_pc;
  logic [63:0] instret_count, cycle_count;
  logic [31:0] jump_count;
  logic pc_misalign;

  int n_pass = 0, n_total = 0;

  top_writeback #(.XLEN(XLEN), .OPLEN(OPLEN), .RF_WE_BIT(WE), .WB_SRC_MEM_BIT(MEM),
                  .RESET_VECTOR('0)) dut (
    .clk(clk), .rst_n(rst_n), .phase_writeback(phase_writeback),
    .decoded_op_mw(decoded_op_mw), .jump_state_mw(jump_state_mw), .rdsel_mw(rdsel_mw),
    .next_pc_mw(next_pc_mw), .alu_out_mw(alu_out_mw), .mem_out_mw(mem_out_mw),
    .rs1sel(rs1sel), .rs2sel(rs2sel), .rs1data(rs1data), .rs2data(rs2data),
    .current_pc(current_pc), .instret_count(instret_count), .cycle_count(cycle_count),
    .jump_count(jump_count), .pc_misalign(pc_misalign));

  always #5 clk = ~clk;

  // Architectural model: state as plain variables, updated per the commit rules.
  logic [XLEN-1:0] m_regs [32];
  logic [XLEN-1:0] m_pc;
  logic [63:0] m_instret, m_cycle;
  logic [31:0] m_jump;
  logic m_mis;

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= '0;
      m_pc <= '0; m_instret <= '0; m_cycle <= '0; m_jump <= '0; m_mis <= 0;
    end else begin
      m_cycle <= m_cycle + 1;
      m_mis <= 0;
      if (phase_writeback) begin
        if (decoded_op_mw[WE] && rdsel_mw != 0)
          m_regs[rdsel_mw] <= decoded_op_mw[MEM] ? mem_out_mw : alu_out_mw;
        if (next_pc_mw % 4 == 0) m_pc <= next_pc_mw;
        else m_mis <= 1;
        m_instret <= m_instret + 1;
        if (jump_state_mw) m_jump <= m_jump + 1;
      end
    end
  end

  function automatic logic [XLEN-1:0] exp_rd(input logic [4:0] sel);
    if (sel == 0) return '0;
    if (phase_writeback && decoded_op_mw[WE] && rdsel_mw != 0 && sel == rdsel_mw)
      return decoded_op_mw[MEM] ? mem_out_mw : alu_out_mw;
    return m_regs[sel];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    chk("pc", current_pc, m_pc);
    chk("instret", instret_count, m_instret);
    chk("jump_count", 64'(jump_count), 64'(m_jump));
    chk("cycle_count", cycle_count, m_cycle);
    chk("pc_misalign", 64'(pc_misalign), 64'(m_mis));
    if (!rst_n) begin
      chk("rs1data", rs1data, exp_rd(rs1sel));
      chk("rs2data", rs2data, exp_rd(rs2sel));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset held for two clocks.
    repeat (2) step();
    chk("rst_pc", current_pc, 64'h0);
    chk("rst_instret", instret_count, 64'h0);
    chk("rst_cycle", cycle_count, 64'h0);
    chk("rst_jump", 64'(jump_count), 64'h0);
    chk("rst_mis", 64'(pc_misalign), 64'h0);
    for (int i = 0; i < 32; i++) begin
      rs1sel = 5'(i); rs2sel = 5'(31 - i); #1;
      chk("rst_rs1", rs1data, 64'h0);
      chk("rst_rs2", rs2data, 64'h0);
    end
    @(negedge clk) rst_n = 0;
    step();

    // ALU writeback to x5, observed through the bypass then from storage.
    decoded_op_mw = 8'b01; rdsel_mw = 5; alu_out_mw = 64'h0123_4567_89AB_CDEF;
    next_pc_mw = 64'h4; rs1sel = 5; phase_writeback = 1; #1;
    chk("bypass_x5", rs1data, 64'h0123_4567_89AB_CDEF);
    step(); phase_writeback = 0; #1;
    chk("x5", rs1data, 64'h0123_4567_89AB_CDEF);
    chk("pc_4", current_pc, 64'h4);
    chk("instret_1", instret_count, 64'd1);

    // Load writeback to x31.
    decoded_op_mw = 8'b11; rdsel_mw = 31; mem_out_mw = 64'hFFFF_FFFF_EFEF_EFEF;
    alu_out_mw = 64'h14; next_pc_mw = 64'h8; phase_writeback = 1;
    step(); phase_writeback = 0; rs2sel = 31; #1;
    chk("x31", rs2data, 64'hFFFF_FFFF_EFEF_EFEF);

    // x0 stays zero.
    decoded_op_mw = 8'b01; rdsel_mw = 0; alu_out_mw = '1; next_pc_mw = 64'hC;
    rs1sel = 0; phase_writeback = 1; #1;
    chk("x0_during", rs1data, 64'h0);
    step(); phase_writeback = 0; #1;
    chk("x0_after", rs1data, 64'h0);

    // Jump, then a misaligned target.
    decoded_op_mw = 8'b00; jump_state_mw = 1; next_pc_mw = 64'h100; phase_writeback = 1;
    step(); phase_writeback = 0; jump_state_mw = 0; #1;
    chk("pc_100", current_pc, 64'h100);
    chk("jump_1", 64'(jump_count), 64'd1);
    decoded_op_mw = 8'b01; rdsel_mw = 3; alu_out_mw = 64'h55; next_pc_mw = 64'h102;
    phase_writeback = 1;
    step(); phase_writeback = 0; rs1sel = 3; #1;
    chk("pc_hold", current_pc, 64'h100);
    chk("mis_pulse", 64'(pc_misalign), 64'd1);
    chk("instret_5", instret_count, 64'd5);
    chk("x3_mis", rs1data, 64'h55);
    step();
    chk("mis_clear", 64'(pc_misalign), 64'd0);

    // Random traffic, including back-to-back writeback cycles.
    for (int n = 0; n < 400; n++) begin
      phase_writeback = ($urandom_range(0, 9) < 4);
      decoded_op_mw = 8'($urandom());
      jump_state_mw = 1'($urandom());
      rdsel_mw = 5'($urandom());
      alu_out_mw = {$urandom(), $urandom()};
      mem_out_mw = {$urandom(), $urandom()};
      next_pc_mw = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) != 0) next_pc_mw[1:0] = 2'b00;
      rs1sel = ($urandom_range(0, 2) == 0) ? rdsel_mw : 5'($urandom());
      rs2sel = ($urandom_range(0, 2) == 0) ? rdsel_mw : 5'($urandom());
      step();
    end

    // Reset in the middle of a writeback cycle carrying a write to x7.
    decoded_op_mw = 8'b01; rdsel_mw = 7; alu_out_mw = 64'h77; next_pc_mw = 64'h40;
    phase_writeback = 1; #2;
    rst_n = 1; #1;
    chk("midrst_pc", current_pc, 64'h0);
    chk("midrst_instret", instret_count, 64'h0);
    step(); phase_writeback = 0; rs1sel = 7; #1;
    chk("midrst_x7", rs1data, 64'h0);
    @(negedge clk) rst_n = 0;
    step(); step();
    chk("cycle_restart", cycle_count, 64'd2);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
